// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// FETCH_CTRL_ALIGN_CHECK_EN selects word-aligning of redirect targets.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HOLD   = 2'd2,
      SQUASH = 2'd3
   } state_t;

   localparam logic [31:0] OFFSET_DEFAULT = 32'h0000_3000;
   localparam int          FETCH_DEPTH    = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   function automatic logic [31:0] redir_target(input logic [31:0] target);
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
      return target & ~32'h3;
`else
      return target;
`endif
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small circular FIFO of {pc, instr} pairs; head is read straight from registers.
// Flush wins over push and pop in the same cycle.
module fetch_buf
   import fetch_ctrl_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [31:0]                  push_pc,
   input  logic [31:0]                  push_instr,
   input  logic                         pop,
   input  logic                         flush,
   output logic [31:0]                  head_pc,
   output logic [31:0]                  head_instr,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] cnt;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         if (push && !pop)
            cnt <= cnt + CW'(1);
         else if (pop && !push)
            cnt <= cnt - CW'(1);
      end
   end

   // Storage needs no reset: nothing reads an entry before it is written.
   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
   end

   assign head_pc    = mem[rd_ptr].pc;
   assign head_instr = mem[rd_ptr].instr;
   assign count      = cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, redirect/squash handling, 2-entry fetch buffer.
// Define FETCH_CTRL_ALIGN_CHECK_EN to flag and word-align misaligned redirect targets.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] OFFSET = OFFSET_DEFAULT,
   parameter int          DEPTH  = FETCH_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        redir_valid,
   input  logic [31:0] redir_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic        align_err
);

   localparam int CW = $clog2(DEPTH + 1);

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   pc;
   logic [31:0]   pc_nxt;
   logic          push;
   logic          pop;
   logic          flush;
   logic [CW-1:0] count;
   logic [CW:0]   occ_after;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pc    <= OFFSET;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      push      = 1'b0;
      flush     = 1'b0;
      mem_req   = 1'b0;
      // A redirect voids any dequeue in the same cycle.
      pop       = instr_valid && instr_ready && !redir_valid;
      occ_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

      case (state)
         IDLE: begin
            state_nxt = FETCH;
            if (redir_valid) begin
               flush  = 1'b1;
               pc_nxt = redir_target(redir_pc);
            end
         end
         FETCH: begin
            mem_req = 1'b1;
            if (redir_valid) begin
               flush     = 1'b1;
               pc_nxt    = redir_target(redir_pc);
               state_nxt = mem_ack ? FETCH : SQUASH;
            end else if (mem_ack) begin
               push      = 1'b1;
               pc_nxt    = pc + 32'd4;
               state_nxt = (occ_after == (CW+1)'(DEPTH)) ? HOLD : FETCH;
            end
         end
         HOLD: begin
            if (redir_valid) begin
               flush     = 1'b1;
               pc_nxt    = redir_target(redir_pc);
               state_nxt = FETCH;
            end else if (pop || (count < CW'(DEPTH))) begin
               state_nxt = FETCH;
            end
         end
         SQUASH: begin
            mem_req = 1'b1;
            if (redir_valid) begin
               flush  = 1'b1;
               pc_nxt = redir_target(redir_pc);
               // An ack arriving with the new redirect is still the stale response.
               if (mem_ack) state_nxt = FETCH;
            end else if (mem_ack) begin
               state_nxt = FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   fetch_buf #(
      .DEPTH (DEPTH)
   ) u_buf (
      .clk        (clk),
      .rst        (reset),
      .push       (push),
      .push_pc    (pc),
      .push_instr (mem_rdata),
      .pop        (pop),
      .flush      (flush),
      .head_pc    (instr_pc),
      .head_instr (instr),
      .count      (count)
   );

   assign mem_addr    = pc;
   assign instr_valid = (count != '0);

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
   logic align_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         align_err_q <= 1'b0;
      else
         align_err_q <= redir_valid && (redir_pc[1:0] != 2'b00);
   end

   assign align_err = align_err_q;
`else
   assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scenarios plus randomized traffic checked against a queue-based fetch model.
module tb_fetch_ctrl;

   localparam logic [31:0] OFF = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        redir_valid = 1'b0;
   logic [31:0] redir_pc = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;
   logic        align_err;

   fetch_ctrl #(.OFFSET(OFF), .DEPTH(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .align_err   (align_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: fetch address, delivered-instruction queue, stale-response flag.
   logic [31:0] m_pc;
   logic [31:0] q_pc[$];
   logic [31:0] q_ins[$];
   bit          m_started;
   bit          m_squash;
   bit          m_aerr;
   bit          align_en;

   function automatic bit exp_req();
      return m_started && (m_squash || (q_pc.size() < 2));
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      chk("mem_req", 32'(mem_req), 32'(exp_req()));
      if (exp_req()) chk("mem_addr", mem_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(q_pc.size() != 0));
      if (q_pc.size() != 0) begin
         chk("instr_pc", instr_pc, q_pc[0]);
         chk("instr", instr, q_ins[0]);
      end
      chk("align_err", 32'(align_err), 32'(m_aerr));
   endtask

   task automatic model_step(input bit ack, input logic [31:0] rd, input bit rv,
                             input logic [31:0] rp, input bit rdy);
      bit          fetching;
      bit          deq;
      logic [31:0] tgt;
      fetching = exp_req() && !m_squash;
      deq      = (q_pc.size() != 0) && rdy && !rv;
      tgt      = align_en ? (rp & ~32'h3) : rp;
      m_aerr   = align_en && rv && (rp[1:0] != 2'b00);
      if (!m_started) begin
         m_started = 1'b1;
         if (rv) begin
            q_pc.delete(); q_ins.delete();
            m_pc = tgt;
         end
      end else if (rv) begin
         if (m_squash) m_squash = !ack;
         else          m_squash = fetching && !ack;
         q_pc.delete(); q_ins.delete();
         m_pc = tgt;
      end else begin
         if (deq) begin
            void'(q_pc.pop_front());
            void'(q_ins.pop_front());
         end
         if (fetching && ack) begin
            q_pc.push_back(m_pc);
            q_ins.push_back(rd);
            m_pc = m_pc + 32'd4;
         end
         if (m_squash && ack) m_squash = 1'b0;
      end
   endtask

   // Called at posedge+2: check, drive, clock, advance model.
   task automatic cycle(input bit ack, input logic [31:0] rd, input bit rv,
                        input logic [31:0] rp, input bit rdy);
      check_outputs();
      mem_ack     = ack;
      mem_rdata   = rd;
      redir_valid = rv;
      redir_pc    = rp;
      instr_ready = rdy;
      @(posedge clk);
      model_step(ack, rd, rv, rp, rdy);
      #2;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      mem_ack     = 1'b0;
      mem_rdata   = '0;
      redir_valid = 1'b0;
      redir_pc    = '0;
      instr_ready = 1'b0;
      m_started   = 1'b0;
      m_squash    = 1'b0;
      m_aerr      = 1'b0;
      m_pc        = OFF;
      q_pc.delete();
      q_ins.delete();
      @(posedge clk);
      #2;
      check_outputs();
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      bit          a;
      bit          rv;
      logic [31:0] rp;
      align_en = 1'b0;
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
      align_en = 1'b1;
`endif

      // Zero-wait streaming
      do_reset();
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("seq_addr0", mem_addr, 32'h3000);
      cycle(1'b1, 32'h1111_0000, 1'b0, 32'h0, 1'b1);
      chk("seq_addr1", mem_addr, 32'h3004);
      chk("seq_ipc0", instr_pc, 32'h3000);
      cycle(1'b1, 32'h1111_0004, 1'b0, 32'h0, 1'b1);
      chk("seq_addr2", mem_addr, 32'h3008);
      chk("seq_ipc1", instr_pc, 32'h3004);
      chk("seq_ins1", instr, 32'h1111_0004);

      // Fill, hold, single pop, refetch
      do_reset();
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 32'h2222_0000, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 32'h2222_0004, 1'b0, 32'h0, 1'b0);
      chk("hold_req", 32'(mem_req), 32'd0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("hold_req2", 32'(mem_req), 32'd0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("refetch_req", 32'(mem_req), 32'd1);
      chk("refetch_addr", mem_addr, 32'h3008);

      // Redirect during a delayed request at 0x3010
      cycle(1'b1, 32'h2222_0008, 1'b0, 32'h0, 1'b1);
      cycle(1'b1, 32'h2222_000C, 1'b0, 32'h0, 1'b1);
      chk("pre_sq_addr", mem_addr, 32'h3010);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1, 32'h3400, 1'b1);
      chk("sq_valid", 32'(instr_valid), 32'd0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
      chk("sq_drop", 32'(instr_valid), 32'd0);
      chk("sq_addr", mem_addr, 32'h3400);
      cycle(1'b1, 32'h3333_3400, 1'b0, 32'h0, 1'b0);
      chk("sq_ipc", instr_pc, 32'h3400);

      // Redirect together with an ack while occupied and ready
      cycle(1'b1, 32'h4444_0000, 1'b1, 32'h5000, 1'b1);
      chk("rda_valid", 32'(instr_valid), 32'd0);
      chk("rda_addr", mem_addr, 32'h5000);

      // PC wrap
      cycle(1'b1, 32'h4444_0004, 1'b1, 32'hFFFF_FFFC, 1'b1);
      cycle(1'b1, 32'hCAFE_0000, 1'b0, 32'h0, 1'b0);
      chk("wrap_addr", mem_addr, 32'h0000_0000);
      chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);

      // Misaligned redirect
      cycle(1'b1, 32'h5555_0000, 1'b1, 32'h3006, 1'b0);
      chk("align_pulse", 32'(align_err), align_en ? 32'd1 : 32'd0);
      chk("align_addr", mem_addr, align_en ? 32'h3004 : 32'h3006);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("align_clear", 32'(align_err), 32'd0);

      // Reset mid-request, late ack in the IDLE cycle is ignored
      do_reset();
      cycle(1'b1, 32'h0BAD_0BAD, 1'b0, 32'h0, 1'b1);
      chk("late_ack_valid", 32'(instr_valid), 32'd0);
      chk("late_ack_addr", mem_addr, 32'h3000);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ((i % 700) == 699) begin
            do_reset();
         end else begin
            a  = exp_req() && ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 15) == 0);
            rp = $urandom();
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
            cycle(a, $urandom(), rv, rp, $urandom_range(0, 1) == 1);
         end
      end
      check_outputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
